vga_timing_gen: RTL
===================

# vga_timing_gen

Raster timing generator for the VGA display path. Produces the `hcount`/`vcount` raster coordinates consumed by every block-drawing stage, and the registered `hsync`/`vsync`/`blank` strobes that drive the DAC and connector. Runs on the pixel clock `vclk`. One-cycle `line_end`/`frame_start` pulses let downstream drawers and game logic rearm per-line and per-frame state.

## Interface
Parameters:
- `H_ACTIVE`, default 1024: visible pixels per line.
- `H_FP`, default 24: horizontal front porch, in clocks.
- `H_SYNC`, default 136: horizontal sync width, in clocks.
- `H_BP`, default 160: horizontal back porch, in clocks.
- `V_ACTIVE`, default 768: visible lines per frame.
- `V_FP`, default 3: vertical front porch, in lines.
- `V_SYNC`, default 6: vertical sync width, in lines.
- `V_BP`, default 29: vertical back porch, in lines.
- `HS_POL`, default 0: active level of `hsync`.
- `VS_POL`, default 0: active level of `vsync`.

Ports:
- `vclk` in 1: pixel clock; the only clock.
- `rst` in 1: reset; synchronous, active-high.
- `hcount` out 11: horizontal position, 0..HT-1, where HT = H_ACTIVE+H_FP+H_SYNC+H_BP (1344 by default).
- `vcount` out 10: line number, 0..VT-1, where VT = V_ACTIVE+V_FP+V_SYNC+V_BP (806 by default).
- `hsync` out 1: horizontal sync, at polarity `HS_POL`.
- `vsync` out 1: vertical sync, at polarity `VS_POL`.
- `blank` out 1: high when `hcount >= H_ACTIVE` or `vcount >= V_ACTIVE`.
- `line_end` out 1: one-cycle pulse while `hcount == HT-1`.
- `frame_start` out 1: one-cycle pulse on the cycle the counters wrap to (0,0).
- `frame_count` out 8: frame counter (see Configuration).

## Operation
- Horizontal FSM states: H_ACT, H_FP, H_SYNC, H_BP. A per-phase down-counter runs inside each state.
  - Transitions occur when the phase counter hits 0: H_ACT→H_FP→H_SYNC→H_BP→H_ACT.
  - `hcount` increments every clock and wraps HT-1→0 on the H_BP→H_ACT transition.
- Vertical FSM states: V_ACT, V_FP, V_SYNC, V_BP, with the same structure. The vertical FSM advances only on cycles where `line_end` = 1.
  - `vcount` increments on `line_end` and wraps VT-1→0.
- `hsync` is at its active level exactly while the horizontal FSM is in H_SYNC, i.e. `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). `vsync` follows the same rule on `vcount`.
- FSM state and the `hcount`/`vcount` decode must agree at all times. A mismatch is a design error and is checked by assertion in the bench.
- Width rules:
  - HT ≤ 2048 and VT ≤ 1024, enforced by elaboration-time check.
  - Counters never take values ≥ HT or ≥ VT.
- Reset, including reset asserted mid-frame: on the next edge, force the following values.
  - `hcount` = 0, `vcount` = 0, states = H_ACT / V_ACT.
  - `hsync` = ~HS_POL, `vsync` = ~VS_POL, `blank` = 0.
  - `line_end` = 0, `frame_start` = 0, `frame_count` = 0.
  - All outputs hold these values while `rst` = 1.

## Timing
- All outputs are registered. `hsync`, `vsync`, `blank`, `line_end` and `frame_start` are computed from the next counter values, so each is cycle-aligned with the `hcount`/`vcount` it describes. There is zero skew between coordinates and strobes.
- First edge with `rst` = 0 gives `hcount` = 1. `frame_start` is not asserted for the post-reset (0,0); the first pulse is on the first natural wrap, HT×VT clocks after reset release.
- `line_end` on the last line coincides with the cycle before `frame_start`.
- A frame is exactly HT×VT clocks: 1,083,264 by default.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: `frame_count` increments modulo 256 on each `frame_start` cycle, and is reset to 0.
- Undefined: `frame_count` is constant 0 and no counter flop is built. The port is always present.

## Structure
- Shared package `vga_pkg`:
  - Default timing constants (`H_ACTIVE` through `V_BP`).
  - Derived HT/VT.
  - Horizontal and vertical state enum typedefs.
  - Coordinate widths (11/10). Drawing blocks reuse these for region compares.
- One sub-module, `vga_axis_ctr`, is instantiated twice, once for each axis. It contains the generic phase FSM plus position counter, with an `adv` enable input: tied 1 for horizontal, driven by `line_end` for vertical.

## Test plan
- Reset release, default params → `hcount` = 0→1→2; `blank` = 0; `hsync` = 1 (inactive); `line_end` first asserts at `hcount` = 1343.
- Line scan → `blank` rises at `hcount` = 1024; `hsync` = 0 for `hcount` 1048..1183 (136 clocks); `vcount` 0→1 exactly at the wrap after `hcount` = 1343.
- Full frame → `vsync` = 0 for `vcount` 771..776; `frame_start` single pulse exactly 1,083,264 clocks after the first (0,0); `frame_count` = 1 with `VGA_TIMING_FRAME_CNT_EN`, 0 without.
- Mid-frame reset at (700, 400) for 3 cycles → all outputs at reset values during reset; no `frame_start` on resume; next pulse one full frame later.
- Small params (H 8/2/2/2, V 4/1/1/1, HS_POL = VS_POL = 1) → HT = 14, VT = 7; `hsync` = 1 for `hcount` 10..11; `vsync` = 1 only on `vcount` 5.
- 300 frames with macro enabled → `frame_count` wraps 255→0; FSM/decode-agreement assertion never fires.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing package: default 1024x768 timing, derived totals,
// coordinate widths and the axis phase state typedefs.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;

    localparam int DEF_HT = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_VT = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int H_W = 11;
    localparam int V_W = 10;

    // Both axes walk the same four phases; the per-axis names alias one encoding.
    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

    typedef phase_e h_state_e;
    typedef phase_e v_state_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: coordinates, sync/blank strobes and frame pulses
// driven by vga_timing_gen (master) to drawing stages and the DAC (slave).
interface vga_timing_if;
    import vga_pkg::*;

    logic [H_W-1:0] hcount;
    logic [V_W-1:0] vcount;
    logic           hsync;
    logic           vsync;
    logic           blank;
    logic           line_end;
    logic           frame_start;
    logic [7:0]     frame_count;

    modport master (
        output hcount, vcount, hsync, vsync, blank, line_end, frame_start, frame_count
    );

    modport slave (
        input hcount, vcount, hsync, vsync, blank, line_end, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen_axis_ctr.sv
// One raster axis: phase FSM with a per-phase down-counter plus the position
// counter. Next-state values are exported so the top can register aligned strobes.
module vga_axis_ctr
    import vga_pkg::*;
#(
    parameter int W      = 11,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BP
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         adv_i,
    output logic [W-1:0] pos_o,
    output logic [W-1:0] pos_d_o,
    output phase_e       state_d_o,
    output logic         wrap_d_o
);

    localparam logic [W-1:0] LEN_ACT  = W'(ACTIVE - 1);
    localparam logic [W-1:0] LEN_FP   = W'(FRONT - 1);
    localparam logic [W-1:0] LEN_SYNC = W'(SYNC - 1);
    localparam logic [W-1:0] LEN_BP   = W'(BACK - 1);

    phase_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] pos_q, pos_d;
    logic         wrap_d;

    // The position only wraps on the back-porch exit, so it can never reach the total.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        if (adv_i) begin
            pos_d = pos_q + 1'b1;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                case (state_q)
                    PH_ACT: begin
                        state_d = PH_FP;
                        cnt_d   = LEN_FP;
                    end
                    PH_FP: begin
                        state_d = PH_SYNC;
                        cnt_d   = LEN_SYNC;
                    end
                    PH_SYNC: begin
                        state_d = PH_BP;
                        cnt_d   = LEN_BP;
                    end
                    default: begin
                        state_d = PH_ACT;
                        cnt_d   = LEN_ACT;
                        pos_d   = '0;
                        wrap_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PH_ACT;
            cnt_q   <= LEN_ACT;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
        end
    end

    assign pos_o     = pos_q;
    assign pos_d_o   = pos_d;
    assign state_d_o = state_d;
    assign wrap_d_o  = wrap_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator on the pixel clock; all strobes registered from
// next counter values. Define VGA_TIMING_FRAME_CNT_EN to build the frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input logic          vclk,
    input logic          rst,
    vga_timing_if.master vga
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (HT > 2048 || VT > 1024) begin : g_size_check
        $error("vga_timing_gen: HT must be <= 2048 and VT <= 1024");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_phase_check
        $error("vga_timing_gen: every timing phase needs at least one clock/line");
    end

    logic [H_W-1:0] hPos, hPos_d;
    logic [V_W-1:0] vPos, vPos_d;
    phase_e         hState_d, vState_d;
    logic           hWrap_d, vWrap_d;

    logic hsync_q, vsync_q, blank_q, lineEnd_q, frameStart_q;

    vga_axis_ctr #(
        .W(H_W), .ACTIVE(H_ACTIVE), .FRONT(H_FP), .SYNC(H_SYNC), .BACK(H_BP)
    ) uHoriz (
        .clk_i    (vclk),
        .rst_i    (rst),
        .adv_i    (1'b1),
        .pos_o    (hPos),
        .pos_d_o  (hPos_d),
        .state_d_o(hState_d),
        .wrap_d_o (hWrap_d)
    );

    vga_axis_ctr #(
        .W(V_W), .ACTIVE(V_ACTIVE), .FRONT(V_FP), .SYNC(V_SYNC), .BACK(V_BP)
    ) uVert (
        .clk_i    (vclk),
        .rst_i    (rst),
        .adv_i    (lineEnd_q),
        .pos_o    (vPos),
        .pos_d_o  (vPos_d),
        .state_d_o(vState_d),
        .wrap_d_o (vWrap_d)
    );

    // Strobes decode the next-state values so they land on the same edge as the coordinates.
    always_ff @(posedge vclk) begin
        if (rst) begin
            hsync_q      <= ~HS_POL;
            vsync_q      <= ~VS_POL;
            blank_q      <= 1'b0;
            lineEnd_q    <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            hsync_q      <= (hState_d == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync_q      <= (vState_d == PH_SYNC) ? VS_POL : ~VS_POL;
            blank_q      <= (hState_d != PH_ACT) || (vState_d != PH_ACT);
            lineEnd_q    <= (hPos_d == H_W'(HT - 1));
            frameStart_q <= hWrap_d && vWrap_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frameCount_q;

    always_ff @(posedge vclk) begin
        if (rst) begin
            frameCount_q <= 8'd0;
        end else if (hWrap_d && vWrap_d) begin
            frameCount_q <= frameCount_q + 8'd1;
        end
    end

    assign vga.frame_count = frameCount_q;
`else
    assign vga.frame_count = 8'd0;
`endif

    assign vga.hcount      = hPos;
    assign vga.vcount      = vPos;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank       = blank_q;
    assign vga.line_end    = lineEnd_q;
    assign vga.frame_start = frameStart_q;

endmodule
